// File: rtl/solver_dispatch.sv
// Host-side initiator for one fractal solver core: loads limb count, iteration
// limit and the c limbs, pulses start, and returns the tagged iteration count.
module solver_dispatch #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32,
  parameter int TAG_BITS        = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cfg_num_limbs_en,
  input  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs,
  input  logic                       cfg_iter_lim_en,
  input  logic [15:0]                cfg_iter_lim,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LIMB_BITS-1:0]       in_cre,
  input  logic [LIMB_BITS-1:0]       in_cim,
  input  logic [TAG_BITS-1:0]        in_tag,
  output logic                       sol_wr_en,
  output logic [LIMB_INDEX_BITS-1:0] sol_wr_ind,
  output logic [LIMB_BITS-1:0]       sol_cre_data,
  output logic [LIMB_BITS-1:0]       sol_cim_data,
  output logic                       sol_wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0] sol_num_limbs_data,
  output logic                       sol_wr_iter_lim_en,
  output logic [15:0]                sol_iter_lim_data,
  output logic                       sol_start,
  input  logic                       sol_out_ready,
  input  logic [15:0]                sol_iteration_count,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_iterations,
  output logic                       out_escaped,
  output logic [TAG_BITS-1:0]        out_tag,
  output logic                       busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_BUSY   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [LIMB_INDEX_BITS-1:0] ONE_LIMB  = LIMB_INDEX_BITS'(1);
  localparam logic [LIMB_INDEX_BITS-1:0] ZERO_LIMB = LIMB_INDEX_BITS'(0);
  localparam logic [15:0]                ITER_SAT  = 16'hFFFF;

  state_t                     state_r;
  state_t                     next_state_s;
  logic [LIMB_INDEX_BITS-1:0] shadow_limbs_r;
  logic [15:0]                shadow_iter_r;
  logic [LIMB_INDEX_BITS-1:0] job_limbs_r;
  logic [LIMB_INDEX_BITS-1:0] beat_cnt_r;
  logic [TAG_BITS-1:0]        tag_r;
  logic                       busy_wait_r;
  logic                       out_valid_r;
  logic [15:0]                out_iterations_r;
  logic                       out_escaped_r;
  logic [TAG_BITS-1:0]        out_tag_r;
  logic                       beat_xfer_s;
  logic                       load_result_s;

  // Next-state and protocol strobes, decoded from the current state.
  always_comb begin
    next_state_s        = state_r;
    in_ready            = 1'b0;
    sol_wr_en           = 1'b0;
    sol_wr_num_limbs_en = 1'b0;
    sol_wr_iter_lim_en  = 1'b0;
    sol_start           = 1'b0;
    beat_xfer_s         = 1'b0;
    load_result_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) next_state_s = ST_CONFIG;
        else          next_state_s = ST_IDLE;
      end
      ST_CONFIG: begin
        sol_wr_num_limbs_en = 1'b1;
        sol_wr_iter_lim_en  = 1'b1;
        next_state_s        = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat_xfer_s = 1'b1;
          sol_wr_en   = 1'b1;
          if (beat_cnt_r == job_limbs_r - ONE_LIMB) next_state_s = ST_START;
          else                                      next_state_s = ST_LOAD;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_START: begin
        sol_start    = 1'b1;
        next_state_s = ST_BUSY;
      end
      ST_BUSY: begin
        // The completion flag may still be stale from the previous job on the
        // first BUSY cycle, so only a later assertion counts.
        if (busy_wait_r && sol_out_ready) next_state_s = ST_DONE;
        else                              next_state_s = ST_BUSY;
      end
      ST_DONE: begin
        if (!out_valid_r || out_ready) begin
          load_result_s = 1'b1;
          next_state_s  = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  assign sol_wr_ind         = beat_cnt_r;
  assign sol_cre_data       = in_cre;
  assign sol_cim_data       = in_cim;
  assign sol_num_limbs_data = shadow_limbs_r;
  assign sol_iter_lim_data  = shadow_iter_r;
  assign busy               = (state_r != ST_IDLE);
  assign out_valid          = out_valid_r;
  assign out_iterations     = out_iterations_r;
  assign out_escaped        = out_escaped_r;
  assign out_tag            = out_tag_r;

  // Shadow configuration registers; a zero limb count is rejected.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_limbs_r <= ONE_LIMB;
      shadow_iter_r  <= 16'd255;
    end else begin
      if (cfg_num_limbs_en && (cfg_num_limbs != ZERO_LIMB)) shadow_limbs_r <= cfg_num_limbs;
      if (cfg_iter_lim_en) shadow_iter_r <= cfg_iter_lim;
    end
  end

  // FSM state plus per-job bookkeeping (limb count, beat counter, tag).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      job_limbs_r <= ONE_LIMB;
      beat_cnt_r  <= ZERO_LIMB;
      tag_r       <= {TAG_BITS{1'b0}};
      busy_wait_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (state_r == ST_CONFIG) begin
        job_limbs_r <= shadow_limbs_r;
        beat_cnt_r  <= ZERO_LIMB;
      end else if (beat_xfer_s) begin
        beat_cnt_r <= beat_cnt_r + ONE_LIMB;
      end
      if (beat_xfer_s && (beat_cnt_r == ZERO_LIMB)) tag_r <= in_tag;
      if (state_r == ST_START)     busy_wait_r <= 1'b0;
      else if (state_r == ST_BUSY) busy_wait_r <= 1'b1;
    end
  end

  // Result register; a reload in the same cycle as a drain wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r      <= 1'b0;
      out_iterations_r <= 16'd0;
      out_escaped_r    <= 1'b0;
      out_tag_r        <= {TAG_BITS{1'b0}};
    end else if (load_result_s) begin
      out_valid_r      <= 1'b1;
      out_iterations_r <= sol_iteration_count;
      out_escaped_r    <= (sol_iteration_count != ITER_SAT);
      out_tag_r        <= tag_r;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_solver_dispatch.sv
// Directed bench for solver_dispatch: a table of jobs driven cycle by cycle,
// plus hand sequences for result back-pressure and mid-job reset.
module tb_solver_dispatch;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_num_limbs_en;
  logic [5:0]  cfg_num_limbs;
  logic        cfg_iter_lim_en;
  logic [15:0] cfg_iter_lim;
  logic        in_valid, in_ready;
  logic [31:0] in_cre, in_cim;
  logic [15:0] in_tag;
  logic        sol_wr_en;
  logic [5:0]  sol_wr_ind;
  logic [31:0] sol_cre_data, sol_cim_data;
  logic        sol_wr_num_limbs_en;
  logic [5:0]  sol_num_limbs_data;
  logic        sol_wr_iter_lim_en;
  logic [15:0] sol_iter_lim_data;
  logic        sol_start;
  logic        sol_out_ready;
  logic [15:0] sol_iteration_count;
  logic        out_valid, out_ready;
  logic [15:0] out_iterations;
  logic        out_escaped;
  logic [15:0] out_tag;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  solver_dispatch #(.LIMB_INDEX_BITS(6), .LIMB_BITS(32), .TAG_BITS(16)) dut (
    .clock(clock), .reset(reset),
    .cfg_num_limbs_en(cfg_num_limbs_en), .cfg_num_limbs(cfg_num_limbs),
    .cfg_iter_lim_en(cfg_iter_lim_en), .cfg_iter_lim(cfg_iter_lim),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cre(in_cre), .in_cim(in_cim), .in_tag(in_tag),
    .sol_wr_en(sol_wr_en), .sol_wr_ind(sol_wr_ind),
    .sol_cre_data(sol_cre_data), .sol_cim_data(sol_cim_data),
    .sol_wr_num_limbs_en(sol_wr_num_limbs_en), .sol_num_limbs_data(sol_num_limbs_data),
    .sol_wr_iter_lim_en(sol_wr_iter_lim_en), .sol_iter_lim_data(sol_iter_lim_data),
    .sol_start(sol_start), .sol_out_ready(sol_out_ready),
    .sol_iteration_count(sol_iteration_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_iterations(out_iterations), .out_escaped(out_escaped),
    .out_tag(out_tag), .busy(busy)
  );

  typedef struct {
    logic        cfg_l_en;
    logic [5:0]  cfg_l;
    logic        cfg_i_en;
    logic [15:0] cfg_i;
    logic [5:0]  conf_cfg;   // limb count written during the CONFIG cycle (0 = none)
    logic [5:0]  busy_cfg;   // limb count written while BUSY (0 = none)
    int          n;
    logic [15:0] iter;
    logic [15:0] tag;
    logic [31:0] cre;
    logic [31:0] cim;
    logic [15:0] res;
    int          gap_at;
    int          gap_len;
    int          delay;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic cle, input logic [5:0] cl, input logic cie,
                              input logic [15:0] ci, input logic [5:0] ccf, input logic [5:0] bcf,
                              input int n, input logic [15:0] iter, input logic [15:0] tag,
                              input logic [31:0] cre, input logic [31:0] cim, input logic [15:0] res,
                              input int gap_at, input int gap_len, input int delay);
    vec_t v;
    v.cfg_l_en = cle; v.cfg_l = cl; v.cfg_i_en = cie; v.cfg_i = ci;
    v.conf_cfg = ccf; v.busy_cfg = bcf; v.n = n; v.iter = iter; v.tag = tag;
    v.cre = cre; v.cim = cim; v.res = res;
    v.gap_at = gap_at; v.gap_len = gap_len; v.delay = delay;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clock);
  endtask

  // Drive one job from IDLE to the cycle the DUT enters DONE.
  task automatic run_job(input vec_t v, input logic pend);
    int k;
    int gap_left;
    in_valid = 1'b1; in_cre = v.cre; in_cim = v.cim; in_tag = v.tag;
    to_neg();
    check("idle_in_ready", in_ready, 32'd0);
    check("idle_busy", busy, 32'd0);
    tick();
    if (v.conf_cfg != 6'd0) begin
      cfg_num_limbs_en = 1'b1; cfg_num_limbs = v.conf_cfg;
    end
    to_neg();
    check("cfg_limbs_en", sol_wr_num_limbs_en, 32'd1);
    check("cfg_limbs_data", sol_num_limbs_data, v.n);
    check("cfg_iter_en", sol_wr_iter_lim_en, 32'd1);
    check("cfg_iter_data", sol_iter_lim_data, v.iter);
    check("cfg_in_ready", in_ready, 32'd0);
    check("cfg_wr_en", sol_wr_en, 32'd0);
    tick();
    cfg_num_limbs_en = 1'b0;
    k = 0;
    gap_left = 0;
    while (k < v.n) begin
      if (gap_left > 0) begin
        in_valid = 1'b0; in_cre = 32'hDEAD_BEEF;
        to_neg();
        check("gap_wr_en", sol_wr_en, 32'd0);
        check("gap_in_ready", in_ready, 32'd1);
        gap_left--;
      end else begin
        in_valid = 1'b1; in_cre = v.cre + k; in_cim = v.cim + k;
        in_tag = (k == 0) ? v.tag : ~v.tag;
        to_neg();
        check("beat_wr_en", sol_wr_en, 32'd1);
        check("beat_wr_ind", sol_wr_ind, k);
        check("beat_cre", sol_cre_data, v.cre + k);
        check("beat_cim", sol_cim_data, v.cim + k);
        check("beat_start", sol_start, 32'd0);
        if (k == v.gap_at) gap_left = v.gap_len;
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    to_neg();
    check("start_pulse", sol_start, 32'd1);
    check("start_wr_en", sol_wr_en, 32'd0);
    check("start_in_ready", in_ready, 32'd0);
    tick();
    // Stale completion flag on the first BUSY cycle must be ignored.
    sol_out_ready = 1'b1; sol_iteration_count = 16'h0BAD;
    to_neg();
    check("busy1_start", sol_start, 32'd0);
    check("busy1_busy", busy, 32'd1);
    tick();
    sol_out_ready = 1'b0;
    for (int d = 0; d < v.delay; d++) begin
      if (d == 0 && v.busy_cfg != 6'd0) begin
        cfg_num_limbs_en = 1'b1; cfg_num_limbs = v.busy_cfg;
      end
      to_neg();
      check("wait_busy", busy, 32'd1);
      check("wait_out_valid", out_valid, pend);
      check("wait_start", sol_start, 32'd0);
      tick();
      cfg_num_limbs_en = 1'b0;
    end
    sol_out_ready = 1'b1; sol_iteration_count = v.res;
    to_neg();
    check("fin_busy", busy, 32'd1);
    tick();
  endtask

  // DUT in DONE with a free result register: load, hold, then drain.
  task automatic collect(input vec_t v);
    out_ready = 1'b0;
    to_neg();
    check("done_busy", busy, 32'd1);
    check("done_out_valid", out_valid, 32'd0);
    tick();
    to_neg();
    check("res_valid", out_valid, 32'd1);
    check("res_iter", out_iterations, v.res);
    check("res_escaped", out_escaped, (v.res != 16'hFFFF) ? 32'd1 : 32'd0);
    check("res_tag", out_tag, v.tag);
    check("res_busy", busy, 32'd0);
    tick();
    out_ready = 1'b1;
    to_neg();
    check("res_hold", out_valid, 32'd1);
    tick();
    out_ready = 1'b0;
    to_neg();
    check("res_drained", out_valid, 32'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb, vc, vd;
    reset = 1'b1; cfg_num_limbs_en = 1'b0; cfg_num_limbs = 6'd0;
    cfg_iter_lim_en = 1'b0; cfg_iter_lim = 16'd0; in_valid = 1'b0;
    in_cre = 32'd0; in_cim = 32'd0; in_tag = 16'd0; sol_out_ready = 1'b0;
    sol_iteration_count = 16'd0; out_ready = 1'b0;

    //             cle   cl    cie   ci        ccf   bcf   n  iter      tag       cre    cim    res       gap    dly
    vecs[0] = mk(1'b0, 6'd0, 1'b0, 16'd0,    6'd0, 6'd0, 1, 16'd255,  16'h00A5, 32'd1, 32'd2, 16'd7,    -1, 0, 2);
    vecs[1] = mk(1'b1, 6'd4, 1'b1, 16'd1000, 6'd0, 6'd0, 4, 16'd1000, 16'h1234, 32'd100, 32'd200, 16'd42, 1, 2, 3);
    vecs[2] = mk(1'b0, 6'd0, 1'b0, 16'd0,    6'd0, 6'd0, 4, 16'd1000, 16'hBEEF, 32'h8000_0000, 32'hFFFF_FFF0, 16'hFFFF, -1, 0, 2);
    vecs[3] = mk(1'b1, 6'd0, 1'b1, 16'd0,    6'd0, 6'd0, 4, 16'd0,    16'h0001, 32'd5, 32'd6, 16'd0,    0, 1, 4);
    vecs[4] = mk(1'b1, 6'd2, 1'b1, 16'd7,    6'd5, 6'd0, 2, 16'd7,    16'h2222, 32'd9, 32'd8, 16'hFFFE, -1, 0, 2);
    vecs[5] = mk(1'b0, 6'd0, 1'b0, 16'd0,    6'd0, 6'd3, 5, 16'd7,    16'h5555, 32'd50, 32'd60, 16'd10, 3, 1, 2);
    vecs[6] = mk(1'b0, 6'd0, 1'b0, 16'd0,    6'd0, 6'd0, 3, 16'd7,    16'h6666, 32'd70, 32'd80, 16'd3,  -1, 0, 2);

    tick(); tick();
    reset = 1'b0;
    to_neg();
    check("rst_in_ready", in_ready, 32'd0);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_strobes", {sol_wr_en, sol_wr_num_limbs_en, sol_wr_iter_lim_en, sol_start}, 32'd0);
    check("rst_out_iter", out_iterations, 32'd0);
    check("rst_out_tag", out_tag, 32'd0);
    check("rst_out_escaped", out_escaped, 32'd0);
    tick();

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].cfg_l_en || vecs[i].cfg_i_en) begin
        cfg_num_limbs_en = vecs[i].cfg_l_en; cfg_num_limbs = vecs[i].cfg_l;
        cfg_iter_lim_en  = vecs[i].cfg_i_en; cfg_iter_lim  = vecs[i].cfg_i;
        tick();
        cfg_num_limbs_en = 1'b0; cfg_iter_lim_en = 1'b0;
      end
      run_job(vecs[i], 1'b0);
      collect(vecs[i]);
    end

    // Back-pressure: result A pending while job B completes.
    va = mk(1'b0, 6'd0, 1'b0, 16'd0, 6'd0, 6'd0, 3, 16'd7, 16'hAAAA, 32'd1, 32'd1, 16'd11, -1, 0, 2);
    vb = mk(1'b0, 6'd0, 1'b0, 16'd0, 6'd0, 6'd0, 3, 16'd7, 16'hBBBB, 32'd2, 32'd2, 16'd22, -1, 0, 2);
    out_ready = 1'b0;
    run_job(va, 1'b0);
    tick();
    to_neg();
    check("bp_a_valid", out_valid, 32'd1);
    check("bp_a_tag", out_tag, 32'hAAAA);
    tick();
    run_job(vb, 1'b1);
    for (int h = 0; h < 2; h++) begin
      to_neg();
      check("bp_hold_busy", busy, 32'd1);
      check("bp_hold_valid", out_valid, 32'd1);
      check("bp_hold_tag", out_tag, 32'hAAAA);
      tick();
    end
    out_ready = 1'b1;
    to_neg();
    check("bp_drain_tag", out_tag, 32'hAAAA);
    check("bp_drain_busy", busy, 32'd1);
    tick();
    to_neg();
    check("bp_b_valid", out_valid, 32'd1);
    check("bp_b_tag", out_tag, 32'hBBBB);
    check("bp_b_iter", out_iterations, 32'd22);
    check("bp_b_busy", busy, 32'd0);
    tick();
    to_neg();
    check("bp_b_drained", out_valid, 32'd0);
    tick();
    out_ready = 1'b0;

    // Reset after beat 1 of a 4-limb job, with a result still pending.
    vc = mk(1'b0, 6'd0, 1'b0, 16'd0, 6'd0, 6'd0, 3, 16'd7, 16'hCCCC, 32'd3, 32'd3, 16'd5, -1, 0, 2);
    run_job(vc, 1'b0);
    tick();
    cfg_num_limbs_en = 1'b1; cfg_num_limbs = 6'd4;
    to_neg();
    check("rj_pending", out_valid, 32'd1);
    tick();
    cfg_num_limbs_en = 1'b0;
    in_valid = 1'b1; in_cre = 32'd40; in_cim = 32'd41; in_tag = 16'hDDDD;
    tick();
    to_neg();
    check("rj_cfg_limbs", sol_num_limbs_data, 32'd4);
    tick();
    to_neg();
    check("rj_beat0", sol_wr_ind, 32'd0);
    tick();
    to_neg();
    check("rj_beat1", sol_wr_ind, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    to_neg();
    check("rj_in_ready", in_ready, 32'd0);
    check("rj_out_valid", out_valid, 32'd0);
    check("rj_busy", busy, 32'd0);
    check("rj_out_tag", out_tag, 32'd0);
    tick();
    vd = mk(1'b0, 6'd0, 1'b0, 16'd0, 6'd0, 6'd0, 1, 16'd255, 16'h7777, 32'd9, 32'd9, 16'd100, -1, 0, 2);
    run_job(vd, 1'b0);
    collect(vd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
